// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK flip-flops with common enable, plus parallel load and
// chained up/down counter modes. Synchronous active-high reset.
module jk_reg_bank #(
  parameter int unsigned WIDTH     = 4,
  parameter logic [31:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc,
  output logic             chg
);

  typedef enum logic [1:0] {
    MODE_JK   = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_UP   = 2'b10,
    MODE_DN   = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] RST_Q = RESET_VAL[WIDTH-1:0];

  mode_e            cur_mode;
  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic [WIDTH-1:0] cell_j;
  logic [WIDTH-1:0] cell_k;
  logic [WIDTH-1:0] q_next;

  assign cur_mode = mode_e'(mode);

  // Counter toggle enables: a cell toggles when every lower cell is 1 (up)
  // or 0 (down); the LSB always toggles.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    if (i == 0) begin : g_lsb
      assign up_t[i] = 1'b1;
      assign dn_t[i] = 1'b1;
    end else begin : g_upper
      assign up_t[i] = &q[i-1:0];
      assign dn_t[i] = ~|q[i-1:0];
    end
  end

  // Every mode is expressed as J/K drive into the same cells: load is J=d,
  // K=~d, and the counters drive J=K=toggle enable.
  always_comb begin
    cell_j = '0;
    cell_k = '0;
    unique case (cur_mode)
      MODE_JK: begin
        cell_j = j;
        cell_k = k;
      end
      MODE_LOAD: begin
        cell_j = d;
        cell_k = ~d;
      end
      MODE_UP: begin
        cell_j = up_t;
        cell_k = up_t;
      end
      MODE_DN: begin
        cell_j = dn_t;
        cell_k = dn_t;
      end
    endcase
  end

  assign q_next = (cell_j & ~q) | (~cell_k & q);

  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= RST_Q;
      chg <= 1'b0;
    end else if (!en) begin
      chg <= 1'b0;
    end else begin
      q   <= q_next;
      chg <= (q_next != q);
    end
  end

  assign qn = ~q;
  assign tc = en & (((cur_mode == MODE_UP) & (&q)) | ((cur_mode == MODE_DN) & ~|q));

endmodule

// File: tb/tb_jk_reg_bank.sv
// Scoreboard bench for jk_reg_bank: a behavioural model predicts each edge,
// plus a two-bank cascade driven by terminal count.
module tb_jk_reg_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] RV = 4'b1010;

  logic       rst, en;
  logic [1:0] mode;
  logic [3:0] j, k, d;
  logic [3:0] q, qn;
  logic       tc, chg;

  logic       c_rst;
  logic [3:0] a_q, a_qn, b_q, b_qn;
  logic       a_tc, a_chg, b_tc, b_chg;

  jk_reg_bank #(.WIDTH(4), .RESET_VAL(32'h0000_000A)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .d(d),
    .q(q), .qn(qn), .tc(tc), .chg(chg)
  );

  jk_reg_bank #(.WIDTH(4), .RESET_VAL(32'h0)) u_bank_a (
    .clk(clk), .rst(c_rst), .en(1'b1), .mode(2'b10), .j(4'h0), .k(4'h0), .d(4'h0),
    .q(a_q), .qn(a_qn), .tc(a_tc), .chg(a_chg)
  );

  jk_reg_bank #(.WIDTH(4), .RESET_VAL(32'h0)) u_bank_b (
    .clk(clk), .rst(c_rst), .en(a_tc), .mode(2'b10), .j(4'h0), .k(4'h0), .d(4'h0),
    .q(b_q), .qn(b_qn), .tc(b_tc), .chg(b_chg)
  );

  typedef struct {
    string      tag;
    logic [3:0] q;
    logic       chg;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] mq;
  bit         mvalid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge: drive inputs, check combinational tc, predict and
  // enqueue the post-edge state, then pop and compare after the edge.
  task automatic cycle(input string tag, input logic r, input logic e, input logic [1:0] m,
                       input logic [3:0] jj, input logic [3:0] kk, input logic [3:0] dd);
    exp_t       x;
    logic [3:0] nq;
    @(negedge clk);
    rst = r; en = e; mode = m; j = jj; k = kk; d = dd;
    #1;
    if (mvalid)
      check({tag, "_tc"}, {31'd0, tc},
            {31'd0, e && ((m == 2'b10 && mq == 4'hF) || (m == 2'b11 && mq == 4'h0))});
    nq = mq;
    if (r) nq = RV;
    else if (e) begin
      case (m)
        2'b00: for (int b = 0; b < 4; b++) begin
          case ({jj[b], kk[b]})
            2'b01:   nq[b] = 1'b0;
            2'b10:   nq[b] = 1'b1;
            2'b11:   nq[b] = ~mq[b];
            default: nq[b] = mq[b];
          endcase
        end
        2'b01:   nq = dd;
        2'b10:   nq = mq + 4'd1;
        default: nq = mq - 4'd1;
      endcase
    end
    x.tag = tag;
    x.q   = nq;
    x.chg = !r && e && (nq != mq);
    sb.push_back(x);
    @(posedge clk);
    #1;
    mq     = nq;
    mvalid = 1'b1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty, got q=%0h expected an entry", tag, q);
    end else begin
      x = sb.pop_front();
      check({x.tag, "_q"}, {28'd0, q}, {28'd0, x.q});
      check({x.tag, "_qn"}, {28'd0, qn}, {28'd0, ~x.q});
      check({x.tag, "_chg"}, {31'd0, chg}, {31'd0, x.chg});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; en = 1'b0; mode = 2'b00; j = '0; k = '0; d = '0;
    c_rst = 1'b1;

    cycle("rst_over_up", 1'b1, 1'b1, 2'b10, 4'h0, 4'h0, 4'h0);
    check("rst_q_const", {28'd0, q}, 32'hA);
    check("rst_qn_const", {28'd0, qn}, 32'h5);

    cycle("load0", 1'b0, 1'b1, 2'b01, 4'hF, 4'hF, 4'h0);
    cycle("jk_mix", 1'b0, 1'b1, 2'b00, 4'b0011, 4'b0101, 4'hF);
    check("jk_mix_const", {28'd0, q}, 32'h3);
    cycle("jk_hold", 1'b0, 1'b1, 2'b00, 4'b0000, 4'b0000, 4'hF);
    cycle("jk_clr_zero", 1'b0, 1'b1, 2'b00, 4'b0000, 4'b0100, 4'h0);
    cycle("jk_toggle", 1'b0, 1'b1, 2'b00, 4'hF, 4'hF, 4'h0);

    cycle("load_e", 1'b0, 1'b1, 2'b01, 4'h0, 4'h0, 4'hE);
    cycle("load_same", 1'b0, 1'b1, 2'b01, 4'h0, 4'h0, 4'hE);
    for (int i = 0; i < 3; i++) cycle("up_wrap", 1'b0, 1'b1, 2'b10, 4'h5, 4'hA, 4'h7);
    check("up_wrap_const", {28'd0, q}, 32'h1);

    cycle("load_1", 1'b0, 1'b1, 2'b01, 4'h0, 4'h0, 4'h1);
    for (int i = 0; i < 2; i++) cycle("dn_wrap", 1'b0, 1'b1, 2'b11, 4'hF, 4'h0, 4'h9);
    check("dn_wrap_const", {28'd0, q}, 32'hF);
    for (int i = 0; i < 2; i++) cycle("hold_en0", 1'b0, 1'b0, 2'b11, 4'hF, 4'hF, 4'h0);

    cycle("load_5", 1'b0, 1'b1, 2'b01, 4'h0, 4'h0, 4'h5);
    cycle("up_a", 1'b0, 1'b1, 2'b10, 4'h0, 4'h0, 4'h0);
    cycle("up_b", 1'b0, 1'b1, 2'b10, 4'h0, 4'h0, 4'h0);
    cycle("mid_rst", 1'b1, 1'b1, 2'b10, 4'h0, 4'h0, 4'h0);
    cycle("after_rst", 1'b0, 1'b1, 2'b10, 4'h0, 4'h0, 4'h0);
    check("after_rst_const", {28'd0, q}, 32'hB);

    for (int i = 0; i < 60; i++)
      cycle("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 4'($urandom));

    @(negedge clk);
    c_rst = 1'b1;
    @(posedge clk);
    #1;
    check("casc_rst_a", {28'd0, a_q}, 32'h0);
    check("casc_rst_b", {28'd0, b_q}, 32'h0);
    @(negedge clk);
    c_rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("casc15_a", {28'd0, a_q}, 32'hF);
    check("casc15_b", {28'd0, b_q}, 32'h0);
    check("casc15_tc", {31'd0, a_tc}, 32'h1);
    @(posedge clk);
    #1;
    check("casc16_a", {28'd0, a_q}, 32'h0);
    check("casc16_b", {28'd0, b_q}, 32'h1);
    check("casc16_tc", {31'd0, a_tc}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
